cannon_seq: RTL and testbench
=============================

CANNON_SEQ -- requirements
Module: cannon_seq

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the grid dimension (N x N processing units, N >= 2).
REQ-002 The block SHALL have parameter W, default 8, meaning the data and accumulator width per unit.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset, the same net that resets the grid units.
REQ-005 The block SHALL have port start, input, 1 bit: request one multiply-and-drain pass.
REQ-006 The block SHALL have port en, output, 1 bit: shift/accumulate enable broadcast to every grid unit.
REQ-007 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 The block SHALL have port s_grid, input, N*N*W bits: all unit sums; unit k = row*N+col occupies bits [k*W +: W].
REQ-009 The block SHALL have port out_data, output, W bits: the streamed result word.
REQ-010 The block SHALL have port out_row, output, clog2(N) bits: the row index of out_data.
REQ-011 The block SHALL have port out_col, output, clog2(N) bits: the column index of out_data.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out_data, out_row, out_col and out_last are valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the word; a transfer occurs on an edge where out_valid && out_ready.
REQ-014 The block SHALL have port out_last, output, 1 bit: marks the final word (row N-1, col N-1).
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse after the final transfer.

Function
REQ-016 The block SHALL implement states IDLE, RUN, CAPTURE and DRAIN.
REQ-017 IDLE: on an edge with start=1, the block SHALL go to RUN and clear the step counter; start SHALL be ignored in every other state.
REQ-018 RUN: en SHALL be 1 for exactly N consecutive cycles; after the Nth cycle the block SHALL go to CAPTURE; en SHALL be 0 in every other state.
REQ-019 CAPTURE: for one cycle with en=0, the block SHALL register all N*N words of s_grid into an internal snapshot, go to DRAIN, and set the index to 0.
REQ-020 DRAIN: out_valid SHALL be 1, and out_data SHALL equal snapshot word[index] with out_row = index / N and out_col = index % N, in row-major order.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last SHALL hold stable.
REQ-022 On each transfer the index SHALL increment by 1, giving one word per cycle when out_ready is held high with no bubbles.
REQ-023 out_last SHALL be 1 only when index = N*N-1.
REQ-024 On the transfer with out_last=1, the block SHALL deassert out_valid, pulse done on the next cycle only, and go to IDLE.
REQ-025 A start asserted on the same edge that completes the drain SHALL be ignored; start is only accepted in IDLE.
REQ-026 Timing: with start sampled at edge 0, en SHALL be 1 in cycles 1..N, CAPTURE SHALL occur in cycle N+1, and the first out_valid SHALL appear in cycle N+2.
REQ-027 Data SHALL pass through unmodified; the block performs no arithmetic on results (the W-bit sums already wrap modulo 2^W in the units).
REQ-028 s_grid changes after CAPTURE SHALL NOT affect streamed data.

Reset
REQ-029 While rst=1, the block SHALL hold state IDLE with en=0, busy=0, out_valid=0, out_last=0, done=0, out_data=0, out_row=0, out_col=0, and the snapshot, index and step counter cleared, asynchronously.
REQ-030 rst asserted mid-RUN or mid-DRAIN SHALL abort immediately; after rst falls, the block SHALL wait in IDLE for a fresh start and SHALL NOT output any partial or stale word.

Verification
REQ-031 Bench: N=4, W=8, start pulse at edge 0 -> en high in exactly cycles 1-4; out_valid first high in cycle 6; busy high in cycles 1 through the drain.
REQ-032 Bench: s_grid word k = k+1, out_ready held 1 -> 16 consecutive words 1..16 with (row,col) from (0,0) to (3,3), out_last only on 16, done pulse in the following cycle.
REQ-033 Bench: out_ready toggled 1,0,0,1 during the drain -> each word held stable across stall cycles, with no loss or duplication.
REQ-034 Bench: s_grid changed to all 0xFF after CAPTURE -> streamed words still equal the snapshot values.
REQ-035 Bench: rst pulsed during the 7th transfer -> all outputs 0 immediately; no transfer until a new start; the next pass streams a full 16 words from (0,0).
REQ-036 Bench: start held high continuously -> passes repeat back-to-back, with exactly one done per pass and en never high during DRAIN.

Source files
------------

// File: rtl/cannon_seq.sv
// cannon_seq: sequencer for an N x N grid of multiply-accumulate units.
// A start request runs the grid for N shift/accumulate steps, snapshots
// every unit sum, then streams the snapshot out row-major over a
// valid/ready channel, one word per accepted transfer.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset (shared with the grid units)
//   start      - request one multiply-and-drain pass (accepted only in IDLE)
//   en         - shift/accumulate enable broadcast to the grid
//   busy       - high whenever the sequencer is not IDLE
//   s_grid     - all unit sums, unit k = row*N+col at bits [k*W +: W]
//   out_data   - streamed result word
//   out_row    - row index of out_data
//   out_col    - column index of out_data
//   out_valid  - out_data/out_row/out_col/out_last are valid
//   out_ready  - consumer accepts the current word
//   out_last   - marks the final word (row N-1, col N-1)
//   done       - one-cycle pulse after the final transfer
module cannon_seq #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   en,
    output logic                   busy,
    input  logic [N*N*W-1:0]       s_grid,
    output logic [W-1:0]           out_data,
    output logic [$clog2(N)-1:0]   out_row,
    output logic [$clog2(N)-1:0]   out_col,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   done
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = N * N;
    localparam int unsigned XW = $clog2(CW);
    localparam int unsigned SW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [SW-1:0]     step, step_next;
    logic [XW-1:0]     idx, idx_next;
    logic [CW*W-1:0]   snap, snap_next;

    logic              en_next;
    logic              busy_next;
    logic              valid_next;
    logic              last_next;
    logic              done_next;
    logic [W-1:0]      data_next;
    logic [IW-1:0]     row_next;
    logic [IW-1:0]     col_next;

    // State, counters and snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            step  <= '0;
            idx   <= '0;
            snap  <= '0;
        end else begin
            state <= state_next;
            step  <= step_next;
            idx   <= idx_next;
            snap  <= snap_next;
        end
    end

    // Next-state logic and the values the output registers will take
    always_comb begin
        state_next = state;
        step_next  = step;
        idx_next   = idx;
        snap_next  = snap;
        done_next  = 1'b0;
        data_next  = '0;
        row_next   = '0;
        col_next   = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    step_next  = '0;
                end
            end
            RUN: begin
                if (step == SW'(N - 1)) begin
                    state_next = CAPTURE;
                end else begin
                    step_next = step + 1'b1;
                end
            end
            CAPTURE: begin
                snap_next  = s_grid;
                idx_next   = '0;
                state_next = DRAIN;
            end
            DRAIN: begin
                // out_valid is registered from state == DRAIN, so a transfer
                // is exactly DRAIN with out_ready.
                if (out_ready) begin
                    if (idx == XW'(CW - 1)) begin
                        state_next = IDLE;
                        idx_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        en_next    = (state_next == RUN);
        busy_next  = (state_next != IDLE);
        valid_next = (state_next == DRAIN);
        last_next  = valid_next && (idx_next == XW'(CW - 1));

        // Present the word the index will point at next cycle; zero when idle
        // so no stale snapshot data is ever visible outside DRAIN.
        if (valid_next) begin
            for (int k = 0; k < int'(CW); k++) begin
                if (idx_next == XW'(k)) begin
                    data_next = snap_next[k*W +: W];
                end
            end
            row_next = IW'(idx_next / XW'(N));
            col_next = IW'(idx_next % XW'(N));
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en        <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            en        <= en_next;
            busy      <= busy_next;
            out_valid <= valid_next;
            out_last  <= last_next;
            done      <= done_next;
            out_data  <= data_next;
            out_row   <= row_next;
            out_col   <= col_next;
        end
    end

endmodule

// File: tb/tb_cannon_seq.sv
// Self-checking bench for cannon_seq (N=4, W=8): pass timing, streamed
// data order, back-pressure, snapshot isolation, mid-drain reset and
// back-to-back passes with start held high.
module tb_cannon_seq;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int NW = N * N;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            en;
    logic            busy;
    logic [NW*W-1:0] s_grid;
    logic [W-1:0]    out_data;
    logic [1:0]      out_row;
    logic [1:0]      out_col;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cannon_seq #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .en        (en),
        .busy      (busy),
        .s_grid    (s_grid),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .done      (done)
    );

    typedef struct {
        logic       en;
        logic       busy;
        logic       valid;
        logic       done;
        logic       last;
        logic [7:0] data;
        logic [1:0] row;
        logic [1:0] col;
    } tvec_t;

    tvec_t      tv [1:23];
    logic [7:0] expw [NW];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Word k = a + b*k, wrapping at 8 bits
    task automatic set_grid(input int a, input int b);
        for (int k = 0; k < NW; k++) begin
            expw[k] = 8'((a + b * k) & 255);
            s_grid[k*W +: W] = expw[k];
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"},    32'(en),        0);
        chk({tag, "_busy"},  32'(busy),      0);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_last"},  32'(out_last),  0);
        chk({tag, "_done"},  32'(done),      0);
        chk({tag, "_data"},  32'(out_data),  0);
        chk({tag, "_row"},   32'(out_row),   0);
        chk({tag, "_col"},   32'(out_col),   0);
    endtask

    // One full pass with out_ready held high; checks every word vs expw
    task automatic run_pass(input string tag);
        int n;
        int seen_done;
        n = 0;
        seen_done = 0;
        out_ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 0; c < 60 && seen_done == 0; c++) begin
            if (done) seen_done = 1;
            if (out_valid) begin
                if (n < NW) begin
                    chk($sformatf("%s_data%0d", tag, n), 32'(out_data), 32'(expw[n]));
                    chk($sformatf("%s_rc%0d", tag, n), {30'd0, out_row, out_col}, 32'(n));
                    chk($sformatf("%s_last%0d", tag, n), 32'(out_last), 32'(n == NW - 1));
                end
                n++;
            end
            if (seen_done == 0) cyc();
        end
        chk({tag, "_words"}, 32'(n), 32'(NW));
        chk({tag, "_done_seen"}, 32'(seen_done), 1);
    endtask

    initial begin
        int n, p, dones, xf, overlap, bad, grid_changed;
        logic pat [4];

        // Expected per-cycle behaviour of a pass started at edge 0
        for (int c = 1; c <= 23; c++) begin
            tv[c].en    = (c >= 1 && c <= 4);
            tv[c].busy  = (c >= 1 && c <= 21);
            tv[c].valid = (c >= 6 && c <= 21);
            tv[c].done  = (c == 22);
            tv[c].last  = (c == 21);
            tv[c].data  = tv[c].valid ? 8'(c - 5) : 8'd0;
            tv[c].row   = tv[c].valid ? 2'((c - 6) / 4) : 2'd0;
            tv[c].col   = tv[c].valid ? 2'((c - 6) % 4) : 2'd0;
        end
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        // Reset state
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        s_grid = '0;
        cyc();
        cyc();
        chk_all_zero("reset");
        rst = 1'b0;
        cyc();

        // Timing and in-order stream, word k = k+1
        set_grid(1, 1);
        out_ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 1; c <= 23; c++) begin
            chk($sformatf("t%0d_en", c),    32'(en),        32'(tv[c].en));
            chk($sformatf("t%0d_busy", c),  32'(busy),      32'(tv[c].busy));
            chk($sformatf("t%0d_valid", c), 32'(out_valid), 32'(tv[c].valid));
            chk($sformatf("t%0d_done", c),  32'(done),      32'(tv[c].done));
            if (tv[c].valid) begin
                chk($sformatf("t%0d_data", c), 32'(out_data), 32'(tv[c].data));
                chk($sformatf("t%0d_row", c),  32'(out_row),  32'(tv[c].row));
                chk($sformatf("t%0d_col", c),  32'(out_col),  32'(tv[c].col));
                chk($sformatf("t%0d_last", c), 32'(out_last), 32'(tv[c].last));
            end
            cyc();
        end

        // Back-pressure 1,0,0,1 plus s_grid overwritten after capture
        set_grid(5, 37);
        out_ready = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        n = 0; p = 0; dones = 0; grid_changed = 0;
        for (int c = 0; c < 200 && dones == 0; c++) begin
            if (done) dones++;
            if (out_valid) begin
                if (grid_changed == 0) begin
                    s_grid = '1;
                    grid_changed = 1;
                end
                if (n < NW) begin
                    chk($sformatf("stall_data%0d", n), 32'(out_data), 32'(expw[n]));
                    chk($sformatf("stall_rc%0d", n), {30'd0, out_row, out_col}, 32'(n));
                    chk($sformatf("stall_last%0d", n), 32'(out_last), 32'(n == NW - 1));
                end else begin
                    chk("stall_extra_word", 32'(out_valid), 0);
                end
                out_ready = pat[p % 4];
                p++;
                if (out_ready) n++;
            end
            cyc();
        end
        chk("stall_words", 32'(n), 32'(NW));
        chk("stall_done", 32'(dones), 1);
        out_ready = 1'b0;
        cyc();

        // Reset while the 7th word is being transferred
        set_grid(1, 1);
        out_ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            if (out_valid) n++;
            cyc();
        end
        chk("mid_reached_word6", {31'd0, out_valid}, 1);
        chk("mid_word6_data", 32'(out_data), 7);
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        cyc();
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (out_valid || busy || en || done) bad++;
        end
        chk("post_rst_quiet", 32'(bad), 0);
        run_pass("after_rst");
        cyc();

        // start held high: back-to-back passes, 22 cycles each
        set_grid(1, 1);
        out_ready = 1'b1;
        start = 1'b1;
        cyc();
        dones = 0; xf = 0; overlap = 0;
        for (int c = 1; c <= 66; c++) begin
            if (done) dones++;
            if (en && out_valid) overlap++;
            if (out_valid && out_ready) begin
                chk($sformatf("b2b_data%0d", xf), 32'(out_data), 32'((xf % NW) + 1));
                xf++;
            end
            cyc();
        end
        start = 1'b0;
        chk("b2b_dones", 32'(dones), 3);
        chk("b2b_xfers", 32'(xf), 48);
        chk("b2b_en_in_drain", 32'(overlap), 0);
        for (int c = 0; c < 30; c++) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
